// File: rtl/exc_commit.sv
// Writeback commit and exception arbitration: resolves all exception sources
// to one cause, pulses the CSR block, then holds flush until redirect drains.
module exc_commit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_fexc_valid,
    input  logic [5:0]  in_fexc_code,
    input  logic [8:0]  in_fexc_sub,
    input  logic [3:0]  in_dexc,
    input  logic        in_mexc_valid,
    input  logic [5:0]  in_mexc_code,
    input  logic [8:0]  in_mexc_sub,
    input  logic [31:0] in_mexc_badv,
    input  logic        in_ertn,
    input  logic        in_refetch,
    input  logic [11:0] is,
    input  logic [11:0] lie,
    input  logic        ie,
    input  logic        exlike,
    output logic        is_exc,
    output logic        is_ertn,
    output logic        is_fetch_again,
    output logic [5:0]  excode,
    output logic [8:0]  esubcode,
    output logic [31:0] badvaddr,
    output logic [31:0] csr_pc,
    output logic        commit_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {IDLE, WAIT_RDR, DRAIN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        int_pend;
    logic        accept;
    logic        exc;
    logic [5:0]  code;
    logic [8:0]  sub;
    logic [31:0] badv;

    assign in_ready = (state == IDLE) && resetn;
    assign flush_o  = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // Cause fields are forced to zero when no exception, CSR relies on it
    always_comb begin
        exc  = 1'b1;
        code = 6'h00;
        sub  = 9'h000;
        badv = 32'h0;
        if (int_pend) begin
            code = 6'h00;
        end else if (in_fexc_valid) begin
            code = in_fexc_code;
            sub  = in_fexc_sub;
            badv = in_pc;
        end else if (in_dexc[0]) begin
            code = 6'h0B;
        end else if (in_dexc[1]) begin
            code = 6'h0C;
        end else if (in_dexc[2]) begin
            code = 6'h0D;
        end else if (in_dexc[3]) begin
            code = 6'h0E;
        end else if (in_mexc_valid) begin
            code = in_mexc_code;
            sub  = in_mexc_sub;
            badv = in_mexc_badv;
        end else begin
            exc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            int_pend       <= 1'b0;
            is_exc         <= 1'b0;
            is_ertn        <= 1'b0;
            is_fetch_again <= 1'b0;
            excode         <= '0;
            esubcode       <= '0;
            badvaddr       <= '0;
            csr_pc         <= '0;
            commit_o       <= 1'b0;
        end else begin
            int_pend       <= ie & (|(is & lie));
            is_exc         <= 1'b0;
            is_ertn        <= 1'b0;
            is_fetch_again <= 1'b0;
            excode         <= '0;
            esubcode       <= '0;
            badvaddr       <= '0;
            csr_pc         <= '0;
            commit_o       <= 1'b0;
            if (accept) begin
                is_exc         <= exc;
                is_ertn        <= !exc && in_ertn;
                is_fetch_again <= !exc && !in_ertn && in_refetch;
                excode         <= code;
                esubcode       <= sub;
                badvaddr       <= badv;
                csr_pc         <= in_pc;
                commit_o       <= !exc;
            end
            case (state)
                IDLE: begin
                    if (accept && (exc || in_ertn || in_refetch))
                        state <= WAIT_RDR;
                end
                WAIT_RDR: begin
                    if (exlike) begin
                        state <= DRAIN;
                        cnt   <= 4'(FLUSH_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (cnt == 4'd0) state <= IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit.sv
// Directed-vector bench for exc_commit with hand-computed expectations.
module tb_exc_commit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_fexc_valid;
    logic [5:0]  in_fexc_code;
    logic [8:0]  in_fexc_sub;
    logic [3:0]  in_dexc;
    logic        in_mexc_valid;
    logic [5:0]  in_mexc_code;
    logic [8:0]  in_mexc_sub;
    logic [31:0] in_mexc_badv;
    logic        in_ertn;
    logic        in_refetch;
    logic [11:0] is;
    logic [11:0] lie;
    logic        ie;
    logic        exlike;
    logic        is_exc;
    logic        is_ertn;
    logic        is_fetch_again;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr;
    logic [31:0] csr_pc;
    logic        commit_o;
    logic        flush_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_commit #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_fexc_valid(in_fexc_valid), .in_fexc_code(in_fexc_code),
        .in_fexc_sub(in_fexc_sub), .in_dexc(in_dexc),
        .in_mexc_valid(in_mexc_valid), .in_mexc_code(in_mexc_code),
        .in_mexc_sub(in_mexc_sub), .in_mexc_badv(in_mexc_badv),
        .in_ertn(in_ertn), .in_refetch(in_refetch),
        .is(is), .lie(lie), .ie(ie), .exlike(exlike),
        .is_exc(is_exc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again),
        .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr),
        .csr_pc(csr_pc), .commit_o(commit_o), .flush_o(flush_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        in_valid      = 1'b0;
        in_pc         = '0;
        in_fexc_valid = 1'b0;
        in_fexc_code  = '0;
        in_fexc_sub   = '0;
        in_dexc       = '0;
        in_mexc_valid = 1'b0;
        in_mexc_code  = '0;
        in_mexc_sub   = '0;
        in_mexc_badv  = '0;
        in_ertn       = 1'b0;
        in_refetch    = 1'b0;
    endtask

    task automatic accept_one(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        tick();
        clear_in();
    endtask

    // Assumes the pulse cycle has just been checked; waits `dly` edges
    // before exlike, then checks the two drain cycles and the return.
    task automatic redirect(input string tag, input int dly);
        for (int i = 1; i < dly; i++) begin
            tick();
            check({tag, "_wait_rdy"}, 32'(in_ready), 32'd0);
            check({tag, "_wait_flush"}, 32'(flush_o), 32'd1);
        end
        exlike = 1'b1;
        tick();
        exlike = 1'b0;
        check({tag, "_drain0"}, 32'(flush_o), 32'd1);
        tick();
        check({tag, "_drain1"}, 32'(flush_o), 32'd1);
        check({tag, "_drain1_rdy"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_done_flush"}, 32'(flush_o), 32'd0);
        check({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        resetn = 1'b0;
        exlike = 1'b0;
        is     = '0;
        lie    = '0;
        ie     = 1'b0;
        clear_in();
        tick();
        tick();
        check("rst_commit", 32'(commit_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_exc", 32'(is_exc), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        resetn = 1'b1;
        #1;
        check("rst_rel_rdy", 32'(in_ready), 32'd1);

        // plain back-to-back stream
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h1c000000 + 32'(i * 4);
            tick();
            check("plain_commit", 32'(commit_o), 32'd1);
            check("plain_pc", csr_pc, 32'h1c000000 + 32'(i * 4));
            check("plain_code", 32'(excode), 32'd0);
            check("plain_flush", 32'(flush_o), 32'd0);
            check("plain_rdy", 32'(in_ready), 32'd1);
        end
        clear_in();
        tick();
        check("plain_end_commit", 32'(commit_o), 32'd0);
        check("plain_end_pc", csr_pc, 32'd0);

        // exlike while idle is ignored
        exlike = 1'b1;
        tick();
        exlike = 1'b0;
        check("idle_exlike_rdy", 32'(in_ready), 32'd1);
        check("idle_exlike_flush", 32'(flush_o), 32'd0);

        // fetch ADE beats memory ALE
        in_fexc_valid = 1'b1;
        in_fexc_code  = 6'h08;
        in_mexc_valid = 1'b1;
        in_mexc_code  = 6'h09;
        in_mexc_badv  = 32'hdeadbeef;
        accept_one(32'h1c000100);
        check("fexc_exc", 32'(is_exc), 32'd1);
        check("fexc_code", 32'(excode), 32'h08);
        check("fexc_badv", badvaddr, 32'h1c000100);
        check("fexc_commit", 32'(commit_o), 32'd0);
        check("fexc_flush", 32'(flush_o), 32'd1);
        check("fexc_rdy", 32'(in_ready), 32'd0);
        tick();
        check("fexc_pulse_end", 32'(is_exc), 32'd0);
        check("fexc_code_end", 32'(excode), 32'd0);
        redirect("fexc", 1);

        // memory TLBR
        in_mexc_valid = 1'b1;
        in_mexc_code  = 6'h3F;
        in_mexc_sub   = 9'h005;
        in_mexc_badv  = 32'h00403abc;
        accept_one(32'h1c000140);
        check("tlbr_code", 32'(excode), 32'h3F);
        check("tlbr_sub", 32'(esubcode), 32'h005);
        check("tlbr_badv", badvaddr, 32'h00403abc);
        tick();
        check("tlbr_code_end", 32'(excode), 32'd0);
        check("tlbr_badv_end", badvaddr, 32'd0);
        redirect("tlbr", 1);

        // decode ordering: BRK over INE, and decode over memory
        in_dexc       = 4'b0110;
        in_mexc_valid = 1'b1;
        in_mexc_code  = 6'h09;
        in_mexc_badv  = 32'h12345678;
        accept_one(32'h1c000180);
        check("brk_code", 32'(excode), 32'h0C);
        check("brk_badv", badvaddr, 32'd0);
        tick();
        redirect("brk", 1);
        in_dexc = 4'b1000;
        accept_one(32'h1c000184);
        check("ipe_code", 32'(excode), 32'h0E);
        tick();
        redirect("ipe", 1);

        // pending interrupt charged to a SYS instruction
        ie      = 1'b1;
        is[11]  = 1'b1;
        lie[11] = 1'b1;
        tick();
        in_dexc = 4'b0001;
        accept_one(32'h1c000200);
        ie = 1'b0;
        check("int_exc", 32'(is_exc), 32'd1);
        check("int_code", 32'(excode), 32'h00);
        check("int_pc", csr_pc, 32'h1c000200);
        check("int_commit", 32'(commit_o), 32'd0);
        tick();
        redirect("int", 1);
        in_dexc = 4'b0001;
        accept_one(32'h1c000200);
        check("sys_code", 32'(excode), 32'h0B);
        check("sys_exc", 32'(is_exc), 32'd1);
        tick();
        redirect("sys", 1);
        is  = '0;
        lie = '0;

        // ERTN wins over refetch, redirect arrives late
        in_ertn    = 1'b1;
        in_refetch = 1'b1;
        accept_one(32'h1c000300);
        check("ertn_pulse", 32'(is_ertn), 32'd1);
        check("ertn_refetch", 32'(is_fetch_again), 32'd0);
        check("ertn_commit", 32'(commit_o), 32'd1);
        check("ertn_exc", 32'(is_exc), 32'd0);
        check("ertn_code", 32'(excode), 32'd0);
        check("ertn_rdy", 32'(in_ready), 32'd0);
        redirect("ertn", 5);

        // refetch alone
        in_refetch = 1'b1;
        accept_one(32'h1c000304);
        check("refetch_pulse", 32'(is_fetch_again), 32'd1);
        check("refetch_commit", 32'(commit_o), 32'd1);
        check("refetch_flush", 32'(flush_o), 32'd1);
        tick();
        redirect("refetch", 1);

        // reset during drain
        in_dexc = 4'b0100;
        accept_one(32'h1c000400);
        check("rstmid_code", 32'(excode), 32'h0D);
        tick();
        exlike = 1'b1;
        tick();
        exlike = 1'b0;
        check("rstmid_drain", 32'(flush_o), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rstmid_flush", 32'(flush_o), 32'd0);
        check("rstmid_rdy", 32'(in_ready), 32'd0);
        check("rstmid_commit", 32'(commit_o), 32'd0);
        tick();
        resetn = 1'b1;
        #1;
        check("rstmid_rel_rdy", 32'(in_ready), 32'd1);
        accept_one(32'h1c000500);
        check("rstmid_commit_new", 32'(commit_o), 32'd1);
        check("rstmid_pc_new", csr_pc, 32'h1c000500);
        check("rstmid_flush_new", 32'(flush_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
